// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
// Shared types and constants for the UART receiver slice.
//   rx_state_t     : receiver FSM states (IDLE, START, DATA, STOP)
//   OVERSAMPLE_DEF : default number of sample strobes per bit period
//   DATA_BITS_DEF  : default number of data bits per frame
//   clog2()        : counter width helper, never returns less than 1
// ----------------------------------------------------------------------------
package uart_pkg;

    localparam int OVERSAMPLE_DEF = 8;
    localparam int DATA_BITS_DEF  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    // Width needed to count 0..value-1. It is clamped to 1 so that a
    // degenerate parameter never produces a zero-width vector.
    function automatic int clog2(input int value);
        int result;
        int span;
        result = 0;
        span   = 1;
        while (span < value) begin
            span   = span * 2;
            result = result + 1;
        end
        return (result < 1) ? 1 : result;
    endfunction

endpackage

// File: rtl/uart_rx_core_if.sv
// ----------------------------------------------------------------------------
// uart_rx_core_if
// Bundles the receiver's line-side inputs and byte-side outputs.
//   samp_clk  : sample enable strobe (ref_clk domain)
//   in        : raw serial line
//   ready     : one-cycle pulse, new byte on out
//   out[7:0]  : last received byte
//   frame_err : stop bit error pulse (only when UART_RX_FRAME_ERR_EN is defined)
// Modports: master = receiver side, slave = line driver / byte consumer side.
// ----------------------------------------------------------------------------
interface uart_rx_core_if;

    logic       samp_clk;
    logic       in;
    logic       ready;
    logic [7:0] out;
`ifdef UART_RX_FRAME_ERR_EN
    logic       frame_err;

    modport master (input samp_clk, input in, output ready, output out, output frame_err);
    modport slave  (output samp_clk, output in, input ready, input out, input frame_err);
`else
    modport master (input samp_clk, input in, output ready, output out);
    modport slave  (output samp_clk, output in, input ready, input out);
`endif

endinterface

// File: rtl/uart_rx_sync.sv
// ----------------------------------------------------------------------------
// uart_rx_sync
// Two-flop synchronizer for the asynchronous serial line.
//   ref_clk  : clock
//   reset    : asynchronous active-low reset, loads PRESET into both flops
//   i_async  : asynchronous input
//   o_sync   : synchronized output
// PRESET is the idle line level so that reset never looks like a start bit.
// ----------------------------------------------------------------------------
module uart_rx_sync #(
    parameter logic PRESET = 1'b0
) (
    input  logic ref_clk,
    input  logic reset,
    input  logic i_async,
    output logic o_sync
);

    logic r_meta;
    logic r_sync;

    // Two back-to-back flops give the first one a full cycle to settle
    // before the value is used by any decision logic.
    always_ff @(posedge ref_clk or negedge reset) begin
        if (!reset) begin
            r_meta <= PRESET;
            r_sync <= PRESET;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/uart_rx_core.sv
// ----------------------------------------------------------------------------
// uart_rx_core
// Oversampling async serial receiver: one start bit, DATA_BITS data bits
// LSB first, one stop bit, no parity.
//   ref_clk : sole clock
//   reset   : asynchronous active-low reset
//   bus     : uart_rx_core_if.master (samp_clk, in, ready, out[, frame_err])
// Parameters: OVERSAMPLE (strobes per bit), DATA_BITS (<=8), IDLE_LEVEL.
// Optional feature macro: UART_RX_FRAME_ERR_EN adds the frame_err pulse.
// ----------------------------------------------------------------------------
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int   OVERSAMPLE = OVERSAMPLE_DEF,
    parameter int   DATA_BITS  = DATA_BITS_DEF,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input logic            ref_clk,
    input logic            reset,
    uart_rx_core_if.master bus
);

    localparam int PH_W  = clog2(OVERSAMPLE);
    localparam int BIT_W = clog2(DATA_BITS + 1);
    localparam int ALIGN = 8 - DATA_BITS;

    localparam logic [PH_W-1:0]  PH_ONE   = PH_W'(1);
    localparam logic [PH_W-1:0]  PH_MID   = PH_W'(OVERSAMPLE / 2);
    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

    logic w_sIn;
    logic w_startLvl;

    rx_state_t        r_state;
    logic [PH_W-1:0]  r_phase;
    logic [BIT_W-1:0] r_bitCnt;
    logic [7:0]       r_shift;
    logic [7:0]       r_out;
    logic             r_ready;
`ifdef UART_RX_FRAME_ERR_EN
    logic             r_frameErr;
`endif

    assign w_startLvl = ~IDLE_LEVEL;

    uart_rx_sync #(
        .PRESET (IDLE_LEVEL)
    ) u_sync (
        .ref_clk (ref_clk),
        .reset   (reset),
        .i_async (bus.in),
        .o_sync  (w_sIn)
    );

    // Receiver FSM. Timing is counted in sample strobes: the start edge is
    // confirmed half a bit later, then every full bit period lands in the
    // middle of the next bit. Data shifts in at the MSB, so after DATA_BITS
    // shifts the byte sits in the top bits and is right-aligned on delivery,
    // which leaves unused MSBs at zero. ready (and frame_err) default low
    // every ref_clk cycle so a pulse lasts exactly one cycle regardless of
    // samp_clk.
    always_ff @(posedge ref_clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_phase    <= '0;
            r_bitCnt   <= '0;
            r_shift    <= '0;
            r_out      <= '0;
            r_ready    <= 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
            r_frameErr <= 1'b0;
`endif
        end else begin
            r_ready    <= 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
            r_frameErr <= 1'b0;
`endif
            if (bus.samp_clk) begin
                unique case (r_state)
                    IDLE: begin
                        if (w_sIn == w_startLvl) begin
                            r_state <= START;
                            r_phase <= PH_ONE;
                        end
                    end
                    START: begin
                        if (r_phase == PH_MID) begin
                            r_phase <= '0;
                            if (w_sIn == w_startLvl) begin
                                r_state  <= DATA;
                                r_bitCnt <= '0;
                                r_shift  <= '0;
                            end else begin
                                r_state <= IDLE;
                            end
                        end else begin
                            r_phase <= r_phase + PH_ONE;
                        end
                    end
                    DATA: begin
                        if (r_phase == PH_LAST) begin
                            r_phase <= '0;
                            r_shift <= {w_sIn, r_shift[7:1]};
                            if (r_bitCnt == BIT_LAST) begin
                                r_state <= STOP;
                            end else begin
                                r_bitCnt <= r_bitCnt + BIT_W'(1);
                            end
                        end else begin
                            r_phase <= r_phase + PH_ONE;
                        end
                    end
                    STOP: begin
                        if (r_phase == PH_LAST) begin
                            r_phase    <= '0;
                            r_bitCnt   <= '0;
                            r_out      <= r_shift >> ALIGN;
                            r_ready    <= 1'b1;
`ifdef UART_RX_FRAME_ERR_EN
                            r_frameErr <= (w_sIn != IDLE_LEVEL);
`endif
                            r_state    <= IDLE;
                        end else begin
                            r_phase <= r_phase + PH_ONE;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        r_phase <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.ready = r_ready;
    assign bus.out   = r_out;
`ifdef UART_RX_FRAME_ERR_EN
    assign bus.frame_err = r_frameErr;
`endif

endmodule

// File: tb/tb_uart_rx_core.sv
// ----------------------------------------------------------------------------
// tb_uart_rx_core
// Self-checking bench for uart_rx_core with default parameters
// (OVERSAMPLE=8, DATA_BITS=8, IDLE_LEVEL=0, samp_clk tied high).
// Frame error checks are active when UART_RX_FRAME_ERR_EN is defined.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_uart_rx_core;

    localparam int BIT_CYCLES = 8;

    typedef struct {
        logic [7:0] data;
        logic       stopVal;
        logic [7:0] expOut;
        logic       expErr;
    } vec_t;

    logic ref_clk;
    logic reset;

    uart_rx_core_if bus ();

    uart_rx_core dut (
        .ref_clk (ref_clk),
        .reset   (reset),
        .bus     (bus.master)
    );

    int checkCount = 0;
    int passCount  = 0;
    int violations = 0;
    int cycleCnt   = 0;
    int startCycle = 0;

    logic [7:0] gotQ[$];
    int         pulseQ[$];
    logic       errQ[$];
    logic [7:0] expQ[$];

    logic       prevReady = 1'b0;
    logic [7:0] prevOut   = 8'h00;

    // Free-running clock with a 10 ns period.
    initial ref_clk = 1'b0;
    always #5 ref_clk = ~ref_clk;

    // Cycle counter used to measure frame-to-ready latency.
    always @(posedge ref_clk) cycleCnt = cycleCnt + 1;

    // Output monitor on the falling edge: collects every delivered byte and
    // flags a ready longer than one cycle, an out change without ready, or
    // a frame_err without ready.
    always @(negedge ref_clk) begin
        if (reset) begin
            if (bus.ready) begin
                gotQ.push_back(bus.out);
                pulseQ.push_back(cycleCnt);
`ifdef UART_RX_FRAME_ERR_EN
                errQ.push_back(bus.frame_err);
`endif
                if (prevReady) violations = violations + 1;
            end else begin
                if (bus.out !== prevOut) violations = violations + 1;
`ifdef UART_RX_FRAME_ERR_EN
                if (bus.frame_err !== 1'b0) violations = violations + 1;
`endif
            end
        end
        prevReady = bus.ready;
        prevOut   = bus.out;
    end

    // Hard stop in case something stalls the stimulus.
    initial begin
        #(100000 * 10);
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount = checkCount + 1;
        if (actual === expected) passCount = passCount + 1;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    // Drive the line to one level for a number of cycles; changes happen on
    // the falling edge so the DUT samples a stable value.
    task automatic applyStimulus(input logic level, input int cycles);
        for (int c = 0; c < cycles; c++) begin
            bus.in = level;
            @(negedge ref_clk);
        end
    endtask

    // Whole frame from the line rules: start at ~idle, data LSB first, stop.
    task automatic sendFrame(input logic [7:0] data, input logic stopVal);
        startCycle = cycleCnt;
        applyStimulus(1'b1, BIT_CYCLES);
        for (int b = 0; b < 8; b++) applyStimulus(((data >> b) & 8'h01) != 0, BIT_CYCLES);
        applyStimulus(stopVal, BIT_CYCLES);
    endtask

    task automatic clearQueues();
        gotQ.delete();
        pulseQ.delete();
        errQ.delete();
        expQ.delete();
    endtask

    vec_t vecs[7];

    initial begin
        logic [7:0] outBefore;
        logic [7:0] rnd;
        int         gap;
        int         lat;

        vecs[0] = '{data: 8'hAC, stopVal: 1'b0, expOut: 8'hAC, expErr: 1'b0};
        vecs[1] = '{data: 8'hA5, stopVal: 1'b0, expOut: 8'hA5, expErr: 1'b0};
        vecs[2] = '{data: 8'h00, stopVal: 1'b0, expOut: 8'h00, expErr: 1'b0};
        vecs[3] = '{data: 8'hFF, stopVal: 1'b0, expOut: 8'hFF, expErr: 1'b0};
        vecs[4] = '{data: 8'h3C, stopVal: 1'b1, expOut: 8'h3C, expErr: 1'b1};
        vecs[5] = '{data: 8'h01, stopVal: 1'b0, expOut: 8'h01, expErr: 1'b0};
        vecs[6] = '{data: 8'h80, stopVal: 1'b0, expOut: 8'h80, expErr: 1'b0};

        reset        = 1'b0;
        bus.in       = 1'b0;
        bus.samp_clk = 1'b1;

        // Reset held, then released on an idle line.
        repeat (16) @(negedge ref_clk);
        checkOutput("reset ready", bus.ready, 0);
        checkOutput("reset out", bus.out, 8'h00);
        reset = 1'b1;
        applyStimulus(1'b0, 16);
        checkOutput("idle ready", bus.ready, 0);
        checkOutput("idle out", bus.out, 8'h00);

        // Table of single frames, each followed by 16 idle cycles.
        for (int v = 0; v < 7; v++) begin
            clearQueues();
            sendFrame(vecs[v].data, vecs[v].stopVal);
            applyStimulus(1'b0, 16);
            checkOutput($sformatf("tbl%0d pulses", v), gotQ.size(), 1);
            checkOutput($sformatf("tbl%0d byte", v), (gotQ.size() > 0) ? gotQ[0] : 8'hxx, vecs[v].expOut);
            checkOutput($sformatf("tbl%0d held out", v), bus.out, vecs[v].expOut);
            lat = (pulseQ.size() > 0) ? pulseQ[0] - startCycle : -1;
            checkOutput($sformatf("tbl%0d latency window", v), (lat >= 76 && lat <= 82), 1);
`ifdef UART_RX_FRAME_ERR_EN
            checkOutput($sformatf("tbl%0d frame_err", v), (errQ.size() > 0) ? errQ[0] : 1'bx, vecs[v].expErr);
`endif
        end

        // Back-to-back frames with no idle gap between them.
        clearQueues();
        applyStimulus(1'b0, 16);
        sendFrame(8'h93, 1'b0);
        sendFrame(8'h4D, 1'b0);
        applyStimulus(1'b0, 16);
        checkOutput("b2b pulses", gotQ.size(), 2);
        checkOutput("b2b first", (gotQ.size() > 0) ? gotQ[0] : 8'hxx, 8'h93);
        checkOutput("b2b second", (gotQ.size() > 1) ? gotQ[1] : 8'hxx, 8'h4D);

        // Short glitch on an idle line must be rejected.
        clearQueues();
        outBefore = bus.out;
        applyStimulus(1'b1, 2);
        applyStimulus(1'b0, 24);
        checkOutput("glitch pulses", gotQ.size(), 0);
        checkOutput("glitch out", bus.out, outBefore);

        // Reset in the middle of the data bits, then a clean frame.
        clearQueues();
        applyStimulus(1'b1, BIT_CYCLES);
        applyStimulus(1'b1, 3 * BIT_CYCLES + 3);
        reset  = 1'b0;
        bus.in = 1'b0;
        repeat (4) @(negedge ref_clk);
        checkOutput("midreset ready", bus.ready, 0);
        checkOutput("midreset out", bus.out, 8'h00);
        reset = 1'b1;
        applyStimulus(1'b0, 16);
        checkOutput("midreset pulses", gotQ.size(), 0);
        sendFrame(8'h55, 1'b0);
        applyStimulus(1'b0, 16);
        checkOutput("post-reset pulses", gotQ.size(), 1);
        checkOutput("post-reset byte", (gotQ.size() > 0) ? gotQ[0] : 8'hxx, 8'h55);

        // Randomized frames with random idle gaps (including zero) against
        // a queue of the bytes that were put on the line.
        clearQueues();
        for (int f = 0; f < 24; f++) begin
            rnd = 8'($urandom_range(0, 255));
            gap = int'($urandom_range(0, 12));
            expQ.push_back(rnd);
            sendFrame(rnd, 1'b0);
            applyStimulus(1'b0, gap);
        end
        applyStimulus(1'b0, 16);
        checkOutput("random count", gotQ.size(), expQ.size());
        for (int k = 0; k < expQ.size(); k++) begin
            checkOutput($sformatf("random byte %0d", k), (k < gotQ.size()) ? gotQ[k] : 8'hxx, expQ[k]);
        end

        checkOutput("protocol violations", violations, 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
